knn_kbest_sorter: RTL and testbench
===================================

KNN_KBEST_SORTER -- requirements
Module: knn_kbest_sorter

Interface
REQ-001 Parameter VAL_WIDTH, default 32: width of incoming distance values.
REQ-002 Parameter K, default 8: number of nearest neighbours retained (2..32).
REQ-003 Parameter IDX_WIDTH, default 16: width of the training-sample index.
REQ-004 clk  input  1  clock; all logic rising-edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 start  input  1  single-cycle pulse: begin a new query, clear the table.
REQ-007 distance  input  VAL_WIDTH  unsigned distance from the upstream distance accumulator.
REQ-008 distanceValid  input  1  distance is valid this cycle; no backpressure; one sample per pulse.
REQ-009 done  input  1  the last sample of the query is presented this cycle or was already presented.
REQ-010 out_dist  output  VAL_WIDTH  distance of the current result entry.
REQ-011 out_idx  output  IDX_WIDTH  training-sample index of the current result entry.
REQ-012 out_valid  output  1  result entry available.
REQ-013 out_ready  input  1  consumer accepts the entry when out_valid&&out_ready.
REQ-014 out_last  output  1  current entry is the final one of the query.
REQ-015 busy  output  1  high in COLLECT and OUTPUT.
REQ-016 query_done  output  1  one-cycle pulse after the last entry is transferred.
REQ-017 idx_overflow  output  1  sticky per query; sample counter saturated.

Function
REQ-018 FSM states IDLE, COLLECT, OUTPUT; the block leaves reset in IDLE.
REQ-019 IDLE: start -> COLLECT; in the same cycle all K slots go invalid, dist=all-ones, sample counter=0, fill count=0, idx_overflow=0.
REQ-020 start in COLLECT or OUTPUT aborts the query, performs the REQ-019 clear and enters COLLECT; no further out_valid for the aborted query.
REQ-021 COLLECT: each distanceValid inserts {distance, counter} into the ascending sorted table in one cycle; counter then increments.
REQ-022 Insertion: new entry goes to the first slot whose dist > distance, or to the first invalid slot; entries at and below that position shift down by one; the slot-K-1 entry is discarded.
REQ-023 Ties: an equal distance is placed after existing equal entries, so the lower index wins.
REQ-024 If the table is full and distance >= slot K-1 dist, the table is unchanged and the counter still increments.
REQ-025 Fill count = min(samples accepted, K).
REQ-026 Counter saturates at 2^IDX_WIDTH-1; a sample accepted at saturation sets idx_overflow and uses index 2^IDX_WIDTH-1.
REQ-027 distanceValid and done in the same cycle: the sample is inserted first, then the FSM enters OUTPUT.
REQ-028 done without distanceValid in COLLECT -> OUTPUT next cycle; done and distanceValid are ignored in IDLE and OUTPUT.
REQ-029 OUTPUT with fill count 0: no out_valid; query_done pulses on the next cycle; FSM returns to IDLE.
REQ-030 OUTPUT: entries are emitted from slot 0 to slot fill-1, ascending; out_valid high and out_dist/out_idx/out_last stable until the handshake.
REQ-031 out_last=1 only with slot fill-1; its handshake -> IDLE, with query_done=1 for the following cycle.
REQ-032 Latency: the first out_valid is one cycle after the COLLECT->OUTPUT transition.
REQ-033 busy is a registered output: 1 in COLLECT/OUTPUT, 0 in IDLE.

Reset
REQ-034 While reset=1 it overrides start: state=IDLE, out_valid=0, out_last=0, out_dist=0, out_idx=0, busy=0, query_done=0, idx_overflow=0, all slots invalid.
REQ-035 Reset mid-COLLECT or mid-OUTPUT discards the query and produces no query_done.

Verification (K=4)
REQ-036 start; distances 50,10,30,20,40; done with the last -> output (10,1),(20,3),(30,2),(40,4); out_last on the 4th; query_done once.
REQ-037 start; distances 7,7,7 then done -> (7,0),(7,1),(7,2); out_last on idx 2.
REQ-038 start; done with no samples -> no out_valid; query_done one cycle later; busy=0 afterwards.
REQ-039 Output with out_ready held low 5 cycles -> out_valid, out_dist and out_idx stable; the entry is then accepted once.
REQ-040 IDX_WIDTH=2; six samples of distance 1 -> idx_overflow=1; indices 0,1,2,3 emitted.
REQ-041 start during OUTPUT after 2 transfers -> out_valid drops; a new query of 5,3 -> (3,1),(5,0).

Source files
------------

// File: rtl/knn_kbest_sorter.sv
// Keeps the K smallest distances of a query in an ascending table, then streams them out.
// Latency: one cycle per inserted sample; first result one cycle after entering OUTPUT.
// Backpressure: none on the sample input; result entries hold until out_valid && out_ready.
module knn_kbest_sorter #(
    parameter int VAL_WIDTH = 32,
    parameter int K         = 8,
    parameter int IDX_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [VAL_WIDTH-1:0] distance,
    input  logic                 distanceValid,
    input  logic                 done,
    output logic [VAL_WIDTH-1:0] out_dist,
    output logic [IDX_WIDTH-1:0] out_idx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 query_done,
    output logic                 idx_overflow
);

    localparam int FW = $clog2(K + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_OUTPUT  = 2'd2;

    localparam logic [IDX_WIDTH-1:0] IDX_MAX = '1;
    localparam logic [FW-1:0]        K_FILL  = FW'(K);

    logic [1:0]           state;
    logic [VAL_WIDTH-1:0] slot_dist [K];
    logic [IDX_WIDTH-1:0] slot_idx  [K];
    logic [K-1:0]         slot_vld;
    logic [IDX_WIDTH-1:0] sample_cnt;
    logic                 sat_used;   // the saturated index value has already been handed out
    logic [FW-1:0]        fill_cnt;
    logic [FW-1:0]        rd_ptr;

    logic [K-1:0]         gt;
    logic [VAL_WIDTH-1:0] nxt_dist [K];
    logic [IDX_WIDTH-1:0] nxt_idx  [K];
    logic [K-1:0]         nxt_vld;

    logic [FW-1:0]        ld_ptr;
    logic [VAL_WIDTH-1:0] sel_dist;
    logic [IDX_WIDTH-1:0] sel_idx;
    logic                 sel_last;

    // Slots that the new sample sorts ahead of; monotonic because the table is ascending
    // and valid entries form a prefix. Strict compare puts ties after existing equals.
    always_comb begin
        gt = '0;
        for (int i = 0; i < K; i++) begin
            gt[i] = !slot_vld[i] || (slot_dist[i] > distance);
        end
    end

    // Table after inserting the current sample: first gt slot takes the sample, later ones shift down.
    always_comb begin
        nxt_dist = slot_dist;
        nxt_idx  = slot_idx;
        nxt_vld  = slot_vld;
        if (gt[0]) begin
            nxt_dist[0] = distance;
            nxt_idx[0]  = sample_cnt;
            nxt_vld[0]  = 1'b1;
        end
        for (int i = 1; i < K; i++) begin
            if (gt[i]) begin
                if (gt[i-1]) begin
                    nxt_dist[i] = slot_dist[i-1];
                    nxt_idx[i]  = slot_idx[i-1];
                    nxt_vld[i]  = slot_vld[i-1];
                end else begin
                    nxt_dist[i] = distance;
                    nxt_idx[i]  = sample_cnt;
                    nxt_vld[i]  = 1'b1;
                end
            end
        end
    end

    // Entry to present next: advance past the current one when it is being accepted.
    always_comb begin
        ld_ptr   = (out_valid && out_ready) ? rd_ptr + FW'(1) : rd_ptr;
        sel_dist = '0;
        sel_idx  = '0;
        for (int i = 0; i < K; i++) begin
            if (FW'(i) == ld_ptr) begin
                sel_dist = slot_dist[i];
                sel_idx  = slot_idx[i];
            end
        end
        sel_last = (ld_ptr == fill_cnt - FW'(1));
    end

    // Query control, table update and result registers.
    always_ff @(posedge clk) begin
        query_done <= 1'b0;
        if (reset) begin
            state        <= S_IDLE;
            slot_vld     <= '0;
            for (int i = 0; i < K; i++) begin
                slot_dist[i] <= '1;
                slot_idx[i]  <= '0;
            end
            sample_cnt   <= '0;
            sat_used     <= 1'b0;
            fill_cnt     <= '0;
            rd_ptr       <= '0;
            out_dist     <= '0;
            out_idx      <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
            idx_overflow <= 1'b0;
        end else if (start) begin
            // A start in any state clears the table and (re)opens collection.
            state        <= S_COLLECT;
            slot_vld     <= '0;
            for (int i = 0; i < K; i++) begin
                slot_dist[i] <= '1;
            end
            sample_cnt   <= '0;
            sat_used     <= 1'b0;
            fill_cnt     <= '0;
            rd_ptr       <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            busy         <= 1'b1;
            idx_overflow <= 1'b0;
        end else begin
            case (state)
                S_COLLECT: begin
                    if (distanceValid) begin
                        slot_dist <= nxt_dist;
                        slot_idx  <= nxt_idx;
                        slot_vld  <= nxt_vld;
                        if (sample_cnt == IDX_MAX) begin
                            if (sat_used) begin
                                idx_overflow <= 1'b1;
                            end
                            sat_used <= 1'b1;
                        end else begin
                            sample_cnt <= sample_cnt + IDX_WIDTH'(1);
                        end
                        if (fill_cnt != K_FILL) begin
                            fill_cnt <= fill_cnt + FW'(1);
                        end
                    end
                    if (done) begin
                        state <= S_OUTPUT;
                    end
                end
                S_OUTPUT: begin
                    if (fill_cnt == '0) begin
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                        query_done <= 1'b1;
                    end else if (!out_valid) begin
                        out_dist  <= sel_dist;
                        out_idx   <= sel_idx;
                        out_last  <= sel_last;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        if (out_last) begin
                            out_valid  <= 1'b0;
                            out_last   <= 1'b0;
                            state      <= S_IDLE;
                            busy       <= 1'b0;
                            query_done <= 1'b1;
                        end else begin
                            rd_ptr   <= ld_ptr;
                            out_dist <= sel_dist;
                            out_idx  <= sel_idx;
                            out_last <= sel_last;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_knn_kbest_sorter.sv
// Bench for knn_kbest_sorter: K=4 instance plus a 2-bit-index instance sharing the inputs.
// Expected results are queued when a query is driven and popped as entries are accepted.
// Output consumer may apply random stalls.
module tb_knn_kbest_sorter;

    localparam int TK = 4;

    typedef struct packed {
        logic [31:0] d;
        logic [15:0] i;
        logic        l;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] distance;
    logic        distanceValid;
    logic        done;
    logic        out_ready;

    logic [31:0] d1_dist;
    logic [15:0] d1_idx;
    logic        d1_valid, d1_last, d1_busy, d1_qd, d1_ovf;
    logic [31:0] d2_dist;
    logic [1:0]  d2_idx;
    logic        d2_valid, d2_last, d2_busy, d2_qd, d2_ovf;

    logic        sel;
    logic [31:0] m_dist;
    logic [15:0] m_idx;
    logic        m_valid, m_last, m_busy, m_qd;

    int total = 0;
    int bad   = 0;
    exp_t exp_q[$];
    int unsigned stim_q[$];

    knn_kbest_sorter #(.VAL_WIDTH(32), .K(TK), .IDX_WIDTH(16)) u_dut (
        .clk(clk), .reset(reset), .start(start), .distance(distance),
        .distanceValid(distanceValid), .done(done),
        .out_dist(d1_dist), .out_idx(d1_idx), .out_valid(d1_valid), .out_ready(out_ready),
        .out_last(d1_last), .busy(d1_busy), .query_done(d1_qd), .idx_overflow(d1_ovf)
    );

    knn_kbest_sorter #(.VAL_WIDTH(32), .K(TK), .IDX_WIDTH(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .distance(distance),
        .distanceValid(distanceValid), .done(done),
        .out_dist(d2_dist), .out_idx(d2_idx), .out_valid(d2_valid), .out_ready(out_ready),
        .out_last(d2_last), .busy(d2_busy), .query_done(d2_qd), .idx_overflow(d2_ovf)
    );

    assign m_dist  = sel ? d2_dist : d1_dist;
    assign m_idx   = sel ? {14'd0, d2_idx} : d1_idx;
    assign m_valid = sel ? d2_valid : d1_valid;
    assign m_last  = sel ? d2_last : d1_last;
    assign m_busy  = sel ? d2_busy : d1_busy;
    assign m_qd    = sel ? d2_qd : d1_qd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drive stim_q; done rides with the last sample or follows as a lone pulse.
    task automatic feed(input bit done_with_last);
        int n;
        n = stim_q.size();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            distanceValid = 1'b1;
            distance      = stim_q[k];
            done          = done_with_last && (k == n - 1);
        end
        @(negedge clk);
        distanceValid = 1'b0;
        done          = 1'b0;
        if (!done_with_last || n == 0) begin
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
        end
    endtask

    task automatic drain(input string name, input bit stall, input int max_cyc, output int first_v);
        int   cyc;
        bit   qd;
        exp_t e;
        cyc = 0;
        qd = 0;
        first_v = -1;
        while (!qd && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (m_qd) begin
                qd = 1;
            end else begin
                if (m_valid && first_v < 0) first_v = cyc;
                out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (m_valid && out_ready) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL %s extra_entry got dist=%0d idx=%0d last=%0d required none",
                                 name, m_dist, m_idx, m_last);
                    end else begin
                        e = exp_q.pop_front();
                        if ({m_dist, m_idx, m_last} !== e) begin
                            bad++;
                            $display("FAIL %s entry got dist=%0d idx=%0d last=%0d required dist=%0d idx=%0d last=%0d",
                                     name, m_dist, m_idx, m_last, e.d, e.i, e.l);
                        end
                    end
                end
            end
        end
        out_ready = 1'b0;
        total++;
        if (!qd) begin
            bad++;
            $display("FAIL %s query_done_timeout got none required pulse within %0d cycles", name, max_cyc);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s missing_entries got %0d left required 0", name, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        total++;
        if (m_qd !== 1'b0 || m_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s after_done got qd=%0b busy=%0b required qd=0 busy=0", name, m_qd, m_busy);
        end
    endtask

    task automatic push(input int unsigned d, input int unsigned i, input bit l);
        exp_t e;
        e.d = d;
        e.i = 16'(i);
        e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        distanceValid = 1'b1;
        done = 1'b1;
        distance = 32'd5;
        repeat (3) @(negedge clk);
        total++;
        if ({d1_valid, d1_last, d1_busy, d1_qd, d1_ovf} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got valid=%0b last=%0b busy=%0b qd=%0b ovf=%0b required all 0",
                     d1_valid, d1_last, d1_busy, d1_qd, d1_ovf);
        end
        total++;
        if (d1_dist !== 32'd0 || d1_idx !== 16'd0) begin
            bad++;
            $display("FAIL reset_data got dist=%0d idx=%0d required 0 0", d1_dist, d1_idx);
        end
        total++;
        if (d2_busy !== 1'b0 || d2_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_dut2 got busy=%0b valid=%0b required 0 0", d2_busy, d2_valid);
        end
        start = 1'b0;
        distanceValid = 1'b0;
        done = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int fv;
        do_start();
        total++;
        if (d1_busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_busy got %0b required 1", d1_busy);
        end
        stim_q = '{50, 10, 30, 20, 40};
        push(10, 1, 0); push(20, 3, 0); push(30, 2, 0); push(40, 4, 1);
        feed(1'b1);
        drain("basic", 1'b0, 40, fv);
        total++;
        if (fv != 1) begin
            bad++;
            $display("FAIL basic_latency got first valid at cycle %0d required 1", fv);
        end
    endtask

    task automatic test_ties();
        int fv;
        do_start();
        stim_q = '{7, 7, 7};
        push(7, 0, 0); push(7, 1, 0); push(7, 2, 1);
        feed(1'b0);
        drain("ties", 1'b0, 40, fv);
    endtask

    task automatic test_empty();
        do_start();
        stim_q.delete();
        feed(1'b0);
        total++;
        if (d1_valid !== 1'b0 || d1_qd !== 1'b0) begin
            bad++;
            $display("FAIL empty_enter got valid=%0b qd=%0b required 0 0", d1_valid, d1_qd);
        end
        @(negedge clk);
        total++;
        if (d1_valid !== 1'b0 || d1_qd !== 1'b1) begin
            bad++;
            $display("FAIL empty_done got valid=%0b qd=%0b required 0 1", d1_valid, d1_qd);
        end
        @(negedge clk);
        total++;
        if (d1_qd !== 1'b0 || d1_busy !== 1'b0) begin
            bad++;
            $display("FAIL empty_after got qd=%0b busy=%0b required 0 0", d1_qd, d1_busy);
        end
    endtask

    task automatic test_stall();
        int   fv;
        int   w;
        exp_t e;
        do_start();
        stim_q = '{9, 4};
        push(4, 1, 0); push(9, 0, 1);
        out_ready = 1'b0;
        feed(1'b1);
        w = 0;
        @(negedge clk);
        while (!d1_valid && w < 5) begin
            @(negedge clk);
            w++;
        end
        for (int s = 0; s < 6; s++) begin
            if (s > 0) @(negedge clk);
            total++;
            if (d1_valid !== 1'b1 || d1_dist !== 32'd4 || d1_idx !== 16'd1) begin
                bad++;
                $display("FAIL stall_hold cycle %0d got valid=%0b dist=%0d idx=%0d required 1 4 1",
                         s, d1_valid, d1_dist, d1_idx);
            end
        end
        out_ready = 1'b1;
        e = exp_q.pop_front();
        total++;
        if ({d1_dist, d1_idx, d1_last} !== e) begin
            bad++;
            $display("FAIL stall_accept got dist=%0d idx=%0d last=%0d required dist=%0d idx=%0d last=%0d",
                     d1_dist, d1_idx, d1_last, e.d, e.i, e.l);
        end
        drain("stall", 1'b0, 40, fv);
    endtask

    task automatic test_overflow();
        int fv;
        sel = 1'b1;
        do_start();
        stim_q = '{1, 1, 1, 1, 1, 1};
        push(1, 0, 0); push(1, 1, 0); push(1, 2, 0); push(1, 3, 1);
        feed(1'b1);
        drain("overflow", 1'b0, 40, fv);
        total++;
        if (d2_ovf !== 1'b1) begin
            bad++;
            $display("FAIL overflow_flag got %0b required 1", d2_ovf);
        end
        total++;
        if (d1_ovf !== 1'b0) begin
            bad++;
            $display("FAIL overflow_wide got %0b required 0", d1_ovf);
        end
        do_start();
        total++;
        if (d2_ovf !== 1'b0) begin
            bad++;
            $display("FAIL overflow_clear got %0b required 0", d2_ovf);
        end
        stim_q.delete();
        feed(1'b0);
        drain("overflow_empty", 1'b0, 20, fv);
        sel = 1'b0;
    endtask

    task automatic test_abort();
        int fv;
        int got;
        int w;
        int unsigned ed[2];
        int unsigned ei[2];
        ed = '{4, 6};
        ei = '{2, 1};
        do_start();
        stim_q = '{8, 6, 4};
        feed(1'b1);
        got = 0;
        w = 0;
        while (got < 2 && w < 20) begin
            @(negedge clk);
            w++;
            out_ready = 1'b1;
            if (d1_valid) begin
                total++;
                if (d1_dist !== ed[got] || d1_idx !== 16'(ei[got])) begin
                    bad++;
                    $display("FAIL abort_pre got dist=%0d idx=%0d required dist=%0d idx=%0d",
                             d1_dist, d1_idx, ed[got], ei[got]);
                end
                got++;
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (d1_valid !== 1'b0 || d1_qd !== 1'b0 || d1_busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_drop got valid=%0b qd=%0b busy=%0b required 0 0 1", d1_valid, d1_qd, d1_busy);
        end
        stim_q = '{5, 3};
        push(3, 1, 0); push(5, 0, 1);
        feed(1'b1);
        drain("abort_new", 1'b0, 40, fv);
    endtask

    task automatic test_reset_mid();
        do_start();
        stim_q = '{1, 2};
        feed(1'b1);
        @(negedge clk);
        reset = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            total++;
            if (d1_qd !== 1'b0 || d1_valid !== 1'b0 || d1_busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid got qd=%0b valid=%0b busy=%0b required 0 0 0", d1_qd, d1_valid, d1_busy);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (d1_qd !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_release got qd=%0b required 0", d1_qd);
        end
    endtask

    // Reference: repeated selection of the smallest unused distance, lowest index first.
    task automatic test_random();
        int fv;
        int n;
        int m;
        int best;
        bit used[16];
        for (int q = 0; q < 6; q++) begin
            n = $urandom_range(0, 10);
            stim_q.delete();
            for (int k = 0; k < n; k++) stim_q.push_back($urandom_range(0, 12));
            m = (n < TK) ? n : TK;
            for (int k = 0; k < 16; k++) used[k] = 1'b0;
            for (int k = 0; k < m; k++) begin
                best = -1;
                for (int j = 0; j < n; j++) begin
                    if (!used[j] && (best < 0 || stim_q[j] < stim_q[best])) best = j;
                end
                used[best] = 1'b1;
                push(stim_q[best], best, k == m - 1);
            end
            do_start();
            feed(1'($urandom_range(0, 1)));
            drain("random", 1'b1, 200, fv);
        end
    endtask

    initial begin
        sel = 1'b0;
        reset = 1'b1;
        start = 1'b0;
        distance = '0;
        distanceValid = 1'b0;
        done = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_ties();
        test_empty();
        test_stall();
        test_overflow();
        test_abort();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
